// File: rtl/baccarat_pkg.sv
// Shared types for the baccarat round scheduler: FSM states, result encoding, default widths.
package baccarat_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DEAL,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } round_state_e;

    // Encoding matches {dealer_win_light, player_win_light}, so lights latch directly.
    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_TIE    = 2'b11
    } result_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != MAX_VAL)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/round_controller.sv
// Round scheduler above the dealing FSM: resets it per round, latches a settled result,
// tallies it, holds it for display, then idles, chains the next round, or ends the session.
module round_controller
    import baccarat_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_ROUNDS  = 9,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             i_slow_clock,
    input  logic             i_resetb,
    input  logic             i_start,
    input  logic             i_auto_run,
    input  logic             i_clear_tally,
    input  logic             i_player_win_light,
    input  logic             i_dealer_win_light,
    output logic             o_round_resetb,
    output logic             o_result_valid,
    output logic [1:0]       o_last_result,
    output logic [CNT_W-1:0] o_round_count,
    output logic [CNT_W-1:0] o_player_wins,
    output logic [CNT_W-1:0] o_dealer_wins,
    output logic [CNT_W-1:0] o_ties,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam int TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROUND_LIMIT = CNT_W'(MAX_ROUNDS);

    round_state_e     r_state;
    round_state_e     w_next;
    logic [TMR_W-1:0] r_tmr;
    logic [1:0]       r_lights_q;
    logic [1:0]       r_last_result;
    logic             r_result_valid;
    logic [1:0]       w_lights;
    logic             w_settled;

    assign w_lights = {i_dealer_win_light, i_player_win_light};

    // Same nonzero lights on two consecutive DEAL cycles filters the transient
    // win light shown before the dealer's third card.
    assign w_settled = (r_state == ST_DEAL) && !i_clear_tally &&
                       (w_lights != RES_NONE) && (w_lights == r_lights_q);

    always_ff @(posedge i_slow_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_DEAL;
            ST_DEAL: begin
                if (w_settled) begin
                    w_next = ST_HOLD;
                end else if (r_tmr == TMO_LAST) begin
                    w_next = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (r_tmr == HOLD_LAST) begin
                    if (o_round_count >= ROUND_LIMIT) begin
                        w_next = ST_DONE;
                    end else if (i_auto_run) begin
                        w_next = ST_CLEAR;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DONE:  w_next = ST_DONE;
            ST_ERROR: if (i_start) w_next = ST_CLEAR;
            default:  w_next = ST_IDLE;
        endcase
        if (i_clear_tally) begin
            w_next = ST_IDLE;
        end
    end

    // One timer shared by DEAL (timeout) and HOLD (display time); restarts on every state change.
    always_ff @(posedge i_slow_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_tmr <= '0;
        end else if ((w_next != r_state) || !((r_state == ST_DEAL) || (r_state == ST_HOLD))) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge i_slow_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_lights_q     <= RES_NONE;
            r_last_result  <= RES_NONE;
            r_result_valid <= 1'b0;
        end else begin
            r_lights_q     <= (r_state == ST_DEAL) ? w_lights : RES_NONE;
            r_result_valid <= w_settled;
            if (i_clear_tally) begin
                r_last_result <= RES_NONE;
            end else if (w_settled) begin
                r_last_result <= w_lights;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_round_cnt (
        .i_clk   (i_slow_clock),
        .i_rst_n (i_resetb),
        .i_clr   (i_clear_tally),
        .i_inc   (w_settled),
        .o_q     (o_round_count)
    );

    sat_counter #(.W(CNT_W)) u_player_cnt (
        .i_clk   (i_slow_clock),
        .i_rst_n (i_resetb),
        .i_clr   (i_clear_tally),
        .i_inc   (w_settled && (w_lights == RES_PLAYER)),
        .o_q     (o_player_wins)
    );

    sat_counter #(.W(CNT_W)) u_dealer_cnt (
        .i_clk   (i_slow_clock),
        .i_rst_n (i_resetb),
        .i_clr   (i_clear_tally),
        .i_inc   (w_settled && (w_lights == RES_DEALER)),
        .o_q     (o_dealer_wins)
    );

    sat_counter #(.W(CNT_W)) u_tie_cnt (
        .i_clk   (i_slow_clock),
        .i_rst_n (i_resetb),
        .i_clr   (i_clear_tally),
        .i_inc   (w_settled && (w_lights == RES_TIE)),
        .o_q     (o_ties)
    );

    assign o_result_valid = r_result_valid;
    assign o_last_result  = r_last_result;
    assign o_round_resetb = (r_state == ST_DEAL) || (r_state == ST_HOLD);
    assign o_busy         = (r_state == ST_CLEAR) || (r_state == ST_DEAL) || (r_state == ST_HOLD);
    assign o_done         = (r_state == ST_DONE);
    assign o_error        = (r_state == ST_ERROR);

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios plus random stimulus, checked every cycle
// against a phase/countdown model of the round rules.
module tb_round_controller;

    localparam int HOLD = 8;
    localparam int MAXR = 3;
    localparam int TMO  = 16;
    localparam int W    = 4;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_DEAL  = 2;
    localparam int P_HOLD  = 3;
    localparam int P_DONE  = 4;
    localparam int P_ERROR = 5;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic start = 1'b0;
    logic auto_run = 1'b0;
    logic clear = 1'b0;
    logic pl = 1'b0;
    logic dl = 1'b0;

    logic         rrb, rv, busy, done, error;
    logic [1:0]   last;
    logic [W-1:0] rc, pw, dw, tw;

    round_controller #(
        .HOLD_CYCLES (HOLD),
        .MAX_ROUNDS  (MAXR),
        .TIMEOUT     (TMO),
        .CNT_W       (W)
    ) dut (
        .i_slow_clock       (clk),
        .i_resetb           (resetb),
        .i_start            (start),
        .i_auto_run         (auto_run),
        .i_clear_tally      (clear),
        .i_player_win_light (pl),
        .i_dealer_win_light (dl),
        .o_round_resetb     (rrb),
        .o_result_valid     (rv),
        .o_last_result      (last),
        .o_round_count      (rc),
        .o_player_wins      (pw),
        .o_dealer_wins      (dw),
        .o_ties             (tw),
        .o_busy             (busy),
        .o_done             (done),
        .o_error            (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: round phase, deal-cycle count, hold countdown and tallies as plain ints.
    int m_ph = P_IDLE, m_dealt = 0, m_hold_left = 0, m_prev = 0;
    int m_rounds = 0, m_pw = 0, m_dw = 0, m_tw = 0, m_last = 0, m_rv = 0;

    function automatic int bump(input int v);
        return (v < (1 << W) - 1) ? v + 1 : v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetb);
            if (!resetb) begin
                m_ph = P_IDLE; m_dealt = 0; m_hold_left = 0; m_prev = 0;
                m_rounds = 0; m_pw = 0; m_dw = 0; m_tw = 0; m_last = 0; m_rv = 0;
            end else begin
                int lt;
                lt = 2 * int'(dl) + int'(pl);
                m_rv = 0;
                if (clear) begin
                    m_rounds = 0; m_pw = 0; m_dw = 0; m_tw = 0; m_last = 0;
                    m_ph = P_IDLE;
                end else begin
                    case (m_ph)
                        P_IDLE:  if (start) m_ph = P_CLEAR;
                        P_CLEAR: begin m_ph = P_DEAL; m_dealt = 0; m_prev = 0; end
                        P_DEAL: begin
                            if (lt != 0 && lt == m_prev) begin
                                m_last = lt; m_rv = 1;
                                m_rounds = bump(m_rounds);
                                if (lt == 1) m_pw = bump(m_pw);
                                if (lt == 2) m_dw = bump(m_dw);
                                if (lt == 3) m_tw = bump(m_tw);
                                m_hold_left = HOLD;
                                m_ph = P_HOLD;
                            end else begin
                                m_dealt++;
                                if (m_dealt == TMO) m_ph = P_ERROR;
                            end
                            m_prev = lt;
                        end
                        P_HOLD: begin
                            m_hold_left--;
                            if (m_hold_left == 0)
                                m_ph = (m_rounds >= MAXR) ? P_DONE : (auto_run ? P_CLEAR : P_IDLE);
                        end
                        P_ERROR: if (start) m_ph = P_CLEAR;
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("round_resetb", int'(rrb), int'(m_ph == P_DEAL || m_ph == P_HOLD));
            chk("result_valid", int'(rv), m_rv);
            chk("last_result", int'(last), m_last);
            chk("round_count", int'(rc), m_rounds);
            chk("player_wins", int'(pw), m_pw);
            chk("dealer_wins", int'(dw), m_dw);
            chk("ties", int'(tw), m_tw);
            chk("busy", int'(busy), int'(m_ph == P_CLEAR || m_ph == P_DEAL || m_ph == P_HOLD));
            chk("done", int'(done), int'(m_ph == P_DONE));
            chk("error", int'(error), int'(m_ph == P_ERROR));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Wait for the next DEAL entry, then play n light pairs (element 0 in seq[1:0]).
    task automatic play_round(input logic [31:0] seq, input int n);
        int t;
        t = 0;
        while (rrb && t < 100) begin @(negedge clk); t++; end
        while (!rrb && t < 100) begin @(negedge clk); t++; end
        chk("deal_entry_in_time", int'(t < 100), 1);
        for (int i = 0; i < n; i++) begin
            {dl, pl} = seq[2*i +: 2];
            @(negedge clk);
        end
        {dl, pl} = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] lr;
        repeat (2) @(negedge clk);
        chk("rst_round_resetb", int'(rrb), 0);
        chk("rst_result_valid", int'(rv), 0);
        chk("rst_last_result", int'(last), 0);
        chk("rst_round_count", int'(rc), 0);
        chk("rst_busy", int'(busy), 0);
        resetb = 1'b1;
        @(negedge clk);

        // Player win after two idle-light cycles
        pulse_start();
        play_round(32'b01_01_00_00, 4);
        chk("t1_result_valid", int'(rv), 1);
        chk("t1_last_result", int'(last), 1);
        chk("t1_player_wins", int'(pw), 1);
        chk("t1_model_pw", m_pw, 1);
        @(negedge clk);
        chk("t1_valid_one_pulse", int'(rv), 0);
        repeat (HOLD) @(negedge clk);
        chk("t1_back_idle", int'(busy), 0);

        // Transient dealer light then tie
        pulse_start();
        play_round(32'b11_11_10_00, 4);
        chk("t2_last_result", int'(last), 3);
        chk("t2_ties", int'(tw), 1);
        chk("t2_dealer_wins", int'(dw), 0);
        chk("t2_round_count", int'(rc), 2);
        @(negedge clk);
        // clear_tally together with start while holding
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("t2c_busy", int'(busy), 0);
        chk("t2c_round_resetb", int'(rrb), 0);
        chk("t2c_round_count", int'(rc), 0);
        chk("t2c_ties", int'(tw), 0);
        chk("t2c_last_result", int'(last), 0);

        // Lights stuck at 00: ERROR after TMO deal cycles
        pulse_start();
        play_round(32'h0, 0);
        repeat (TMO - 1) @(negedge clk);
        chk("t3_not_yet_error", int'(error), 0);
        @(negedge clk);
        chk("t3_error", int'(error), 1);
        chk("t3_round_count", int'(rc), 0);
        // Retry; settles on the final allowed deal cycle, which must beat the timeout
        pulse_start();
        play_round(32'h5000_0000, 16);
        chk("t3_retry_no_error", int'(error), 0);
        chk("t3_retry_player", int'(pw), 1);
        chk("t3_retry_rounds", int'(rc), 1);
        repeat (HOLD + 1) @(negedge clk);

        // Auto-run session to MAXR
        pulse_clear();
        auto_run = 1'b1;
        pulse_start();
        for (int r = 0; r < MAXR; r++) play_round(32'b01_01, 2);
        repeat (HOLD + 1) @(negedge clk);
        chk("t4_done", int'(done), 1);
        chk("t4_round_count", int'(rc), 3);
        chk("t4_player_wins", int'(pw), 3);
        auto_run = 1'b0;
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        chk("t4_start_ignored", int'(done), 1);
        chk("t4_not_busy", int'(busy), 0);

        // Async reset in the middle of a deal
        pulse_clear();
        pulse_start();
        play_round(32'b01_01, 2);
        repeat (HOLD + 1) @(negedge clk);
        pulse_start();
        play_round(32'h0, 1);
        #2 resetb = 1'b0;
        #1;
        chk("t5_round_resetb", int'(rrb), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_round_count", int'(rc), 0);
        chk("t5_player_wins", int'(pw), 0);
        #1 resetb = 1'b1;
        @(negedge clk);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 40) == 0) auto_run = ~auto_run;
            if ($urandom_range(0, 2) == 0) begin
                lr = 2'($urandom_range(0, 3));
                {dl, pl} = lr;
            end
            if ($urandom_range(0, 500) == 0) begin
                #2 resetb = 1'b0;
                #2 resetb = 1'b1;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
